// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_pkg
//  Purpose  : Shared frame geometry, bus widths and writer state encoding.
//             Imported by the frame RAM writer and by the display-side block
//             so both agree on frame size and address/pixel widths.
//  Revision : 1.0  initial release
// ============================================================================
package frame_pkg;

    localparam int H_ACT     = 480;            // active pixels per line
    localparam int V_ACT     = 270;            // active lines per frame
    localparam int FRAME_PIX = H_ACT * V_ACT;  // words per frame (129600)
    localparam int ADDR_W    = 17;             // RAM address width
    localparam int PIX_W     = 24;             // RGB888 pixel width
    localparam int CNT_W     = 9;              // line / column counter width

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REL = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_ram_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pix_stream_if / ram_wr_if
//  Purpose  : Bus bundles used by frame_ram_writer.
//             pix_stream_if : incoming pixel stream (valid, sof, RGB888 data)
//                             master = pixel source, slave = writer
//             ram_wr_if     : RAM write port (enable, address, data)
//                             master = writer, slave = RAM
//  Revision : 1.0  initial release
// ============================================================================
interface pix_stream_if;
    import frame_pkg::*;

    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_data;

    modport master (output pix_valid, output pix_sof, output pix_data);
    modport slave  (input  pix_valid, input  pix_sof, input  pix_data);
endinterface

interface ram_wr_if;
    import frame_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/frame_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_addr_gen
//  Purpose  : Frame write-pointer generator. Holds the linear RAM address
//             plus column/line position of the next pixel to be written.
//  Ports    : clk, rst_n   clock, synchronous active-low reset
//             i_clr        restart the pointer at address 0
//             i_inc        advance the pointer by one pixel (applied after
//                          i_clr when both are high)
//             o_addr       current pointer
//             o_last       pointer sits on the final pixel of the frame
//  Revision : 1.0  initial release
// ============================================================================
module frame_addr_gen #(
    parameter int H_ACT = frame_pkg::H_ACT,
    parameter int V_ACT = frame_pkg::V_ACT
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        i_clr,
    input  wire logic                        i_inc,
    output logic      [frame_pkg::ADDR_W-1:0] o_addr,
    output logic                             o_last
);
    import frame_pkg::*;

    localparam logic [CNT_W-1:0]  c_COL_LAST  = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0]  c_LINE_LAST = CNT_W'(V_ACT - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr, w_addr_base, w_addr_nxt;
    logic [CNT_W-1:0]  r_col,  w_col_base,  w_col_nxt;
    logic [CNT_W-1:0]  r_line, w_line_base, w_line_nxt;

    // Clear selects the base, increment is then applied to that base, so
    // clear+increment lands on address 1 (used when a pixel is written to 0).
    always_comb begin
        w_addr_base = i_clr ? '0 : r_addr;
        w_col_base  = i_clr ? '0 : r_col;
        w_line_base = i_clr ? '0 : r_line;
        w_addr_nxt  = w_addr_base;
        w_col_nxt   = w_col_base;
        w_line_nxt  = w_line_base;
        if (i_inc) begin
            w_addr_nxt = w_addr_base + c_ADDR_ONE;
            if (w_col_base == c_COL_LAST) begin
                w_col_nxt  = '0;
                w_line_nxt = w_line_base + c_CNT_ONE;
            end else begin
                w_col_nxt  = w_col_base + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_col  <= '0;
            r_line <= '0;
        end else begin
            r_addr <= w_addr_nxt;
            r_col  <= w_col_nxt;
            r_line <= w_line_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_col == c_COL_LAST) && (r_line == c_LINE_LAST);

endmodule
`default_nettype wire

// File: rtl/frame_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_ram_writer
//  Purpose  : Captures one complete video frame into a frame RAM on request,
//             waiting for the display side to release the RAM first, then
//             asks the display to switch over to the RAM image.
//  Ports    : clk, rst_n     pixel clock, synchronous active-low reset
//             start          one-cycle capture request
//             frame_sw_ram   1 = display is currently reading the RAM
//             pix            pixel stream (slave)
//             ram            registered RAM write port (master)
//             switch_ram     request display to show RAM instead of ROM
//             pic_done       sticky: a full frame was written since reset
//             busy           capture in progress
//             sof_err        one-cycle pulse on a start-of-frame mid-frame
//  Revision : 1.0  initial release
// ============================================================================
module frame_ram_writer #(
    parameter int H_ACT     = frame_pkg::H_ACT,
    parameter int V_ACT     = frame_pkg::V_ACT,
    parameter int FRAME_PIX = H_ACT * V_ACT
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   start,
    input  wire logic   frame_sw_ram,
    pix_stream_if.slave pix,
    ram_wr_if.master    ram,
    output logic        switch_ram,
    output logic        pic_done,
    output logic        busy,
    output logic        sof_err
);
    import frame_pkg::*;

    // A one-word frame finishes on the very pixel that restarts the pointer.
    localparam bit c_ONE_PIX = (FRAME_PIX == 1);

    state_t            r_state, w_state_nxt;
    logic              w_start_acc;
    logic              w_accept;
    logic              w_restart;
    logic              w_sof_err;
    logic              w_last;
    logic              w_gen_clr;
    logic              w_gen_inc;
    logic              w_gen_last;
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] w_wr_addr;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_sof_err;
    logic              r_fin;
    logic              r_switch_ram;
    logic              r_pic_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_accept    = 1'b0;
        w_restart   = 1'b0;
        w_sof_err   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_WAIT_REL;
                    w_start_acc = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                // Only write once the display has let go of the RAM.
                if (!frame_sw_ram) begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (pix.pix_valid && pix.pix_sof) begin
                    w_accept    = 1'b1;
                    w_restart   = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (pix.pix_valid) begin
                    w_accept = 1'b1;
                    if (pix.pix_sof) begin
                        // Resynchronise on the new frame boundary.
                        w_restart = 1'b1;
                        w_sof_err = (w_ptr != '0);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_last = w_accept && (w_restart ? c_ONE_PIX : w_gen_last);
        if (w_last) begin
            w_state_nxt = ST_DONE;
        end
    end

    // The pointer is parked at 0 after the final write so it never runs
    // past the end of the frame.
    assign w_gen_clr = w_start_acc | w_restart | w_last;
    assign w_gen_inc = w_accept & ~w_last;
    assign w_wr_addr = w_restart ? '0 : w_ptr;

    frame_addr_gen #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_gen_clr),
        .i_inc  (w_gen_inc),
        .o_addr (w_ptr),
        .o_last (w_gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_sof_err    <= 1'b0;
            r_fin        <= 1'b0;
            r_switch_ram <= 1'b0;
            r_pic_done   <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_sof_err <= w_sof_err;
            r_fin     <= w_last;
            if (w_accept) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= pix.pix_data;
            end
            // r_fin marks the cycle the final write is on the bus; the
            // display is told to switch only after that write has landed.
            if (w_start_acc) begin
                r_switch_ram <= 1'b0;
            end else if (r_fin) begin
                r_switch_ram <= 1'b1;
            end
            if (r_fin) begin
                r_pic_done <= 1'b1;
            end
        end
    end

    assign ram.wr_en   = r_wr_en;
    assign ram.wr_addr = r_wr_addr;
    assign ram.wr_data = r_wr_data;
    assign switch_ram  = r_switch_ram;
    assign pic_done    = r_pic_done;
    assign sof_err     = r_sof_err;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_frame_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_ram_writer
//  Purpose  : Directed self-checking bench for frame_ram_writer using a
//             reduced 8x4 frame (32 words).
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_ram_writer;

    localparam int TB_H  = 8;
    localparam int TB_V  = 4;
    localparam int TB_FP = TB_H * TB_V;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic frame_sw_ram = 1'b0;
    logic switch_ram, pic_done, busy, sof_err;

    pix_stream_if pix ();
    ram_wr_if     ram ();

    frame_ram_writer #(
        .H_ACT     (TB_H),
        .V_ACT     (TB_V),
        .FRAME_PIX (TB_FP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .frame_sw_ram (frame_sw_ram),
        .pix          (pix),
        .ram          (ram),
        .switch_ram   (switch_ram),
        .pic_done     (pic_done),
        .busy         (busy),
        .sof_err      (sof_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic v, input logic s, input logic [23:0] d);
        pix.pix_valid = v;
        pix.pix_sof   = s;
        pix.pix_data  = d;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        px(1'b0, 1'b0, 24'h0);
        start = 1'b0;
    endtask

    task automatic exp_wr(input string tag, input int a, input logic [23:0] d);
        chk({tag, ".en"},   32'(ram.wr_en), 32'd1);
        chk({tag, ".addr"}, 32'(ram.wr_addr), 32'(a));
        chk({tag, ".data"}, 32'(ram.wr_data), 32'(d));
    endtask

    // Sends n accepted pixels to addresses 0..n-1 (sof on the first), with
    // optional random gaps, and a stray start pulse that must be ignored.
    task automatic frame_run(input string tag, input int n, input bit rnd);
        int          a;
        logic        v;
        logic [23:0] d;
        a = 0;
        while (a < n) begin
            v     = (rnd && a != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            d     = 24'($urandom);
            start = (a == 5);
            px(v, (a == 0), d);
            start = 1'b0;
            if (v) begin
                exp_wr(tag, a, d);
                a++;
            end else begin
                chk({tag, ".gap"}, 32'(ram.wr_en), 32'd0);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_en"},      32'(ram.wr_en),   32'd0);
        chk({tag, ".wr_addr"},    32'(ram.wr_addr), 32'd0);
        chk({tag, ".wr_data"},    32'(ram.wr_data), 32'd0);
        chk({tag, ".switch_ram"}, 32'(switch_ram),  32'd0);
        chk({tag, ".pic_done"},   32'(pic_done),    32'd0);
        chk({tag, ".busy"},       32'(busy),        32'd0);
        chk({tag, ".sof_err"},    32'(sof_err),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] d;
        pix.pix_valid = 1'b0;
        pix.pix_sof   = 1'b0;
        pix.pix_data  = 24'h0;

        // ---------------- reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        // no write right after release, start not yet given
        rst_n = 1'b1;
        px(1'b1, 1'b1, 24'h123456);
        chk("idle.en", 32'(ram.wr_en), 32'd0);

        // ---------------- full frame with display already released
        pulse_start();
        chk("t1.busy", 32'(busy), 32'd1);
        chk("t1.sw",   32'(switch_ram), 32'd0);
        px(1'b1, 1'b0, 24'h111111);           // WAIT_REL -> WAIT_SOF
        chk("t1.rel.en", 32'(ram.wr_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            px(1'b1, 1'b0, 24'h222222);       // no sof: discarded
            chk("t1.nosof.en", 32'(ram.wr_en), 32'd0);
        end
        frame_run("t1", TB_FP, 1'b0);
        chk("t1.last.sw",   32'(switch_ram), 32'd0);
        chk("t1.last.done", 32'(pic_done),   32'd0);
        chk("t1.last.busy", 32'(busy),       32'd0);
        px(1'b1, 1'b1, 24'h333333);           // extra pixel in DONE
        chk("t1.fin.en",   32'(ram.wr_en), 32'd0);
        chk("t1.fin.sw",   32'(switch_ram), 32'd1);
        chk("t1.fin.done", 32'(pic_done),   32'd1);
        px(1'b1, 1'b0, 24'h444444);
        chk("t1.done2.en", 32'(ram.wr_en), 32'd0);

        // ---------------- display holds the RAM for 50 cycles
        frame_sw_ram = 1'b1;
        pulse_start();
        chk("t2.sw_clear",  32'(switch_ram), 32'd0);
        chk("t2.busy",      32'(busy),       32'd1);
        chk("t2.done_stk",  32'(pic_done),   32'd1);
        for (int i = 0; i < 50; i++) begin
            px(1'b1, 1'b1, 24'(i));
            chk("t2.hold.en", 32'(ram.wr_en), 32'd0);
        end
        frame_sw_ram = 1'b0;
        px(1'b0, 1'b0, 24'h0);
        frame_run("t2", TB_FP, 1'b1);         // random valid gaps
        chk("t2.last.sw", 32'(switch_ram), 32'd0);
        px(1'b0, 1'b0, 24'h0);
        chk("t2.fin.sw", 32'(switch_ram), 32'd1);

        // ---------------- sof in the middle of a frame
        pulse_start();
        chk("t3.sw_clear", 32'(switch_ram), 32'd0);
        px(1'b0, 1'b0, 24'h0);
        frame_run("t3pre", 10, 1'b0);
        chk("t3pre.err", 32'(sof_err), 32'd0);
        d = 24'hABCDEF;
        px(1'b1, 1'b1, d);
        exp_wr("t3.resync", 0, d);
        chk("t3.err_pulse", 32'(sof_err), 32'd1);
        for (int a = 1; a < TB_FP; a++) begin
            d = 24'($urandom);
            px(1'b1, 1'b0, d);
            exp_wr("t3", a, d);
            if (a == 1) chk("t3.err_end", 32'(sof_err), 32'd0);
        end
        chk("t3.last.sw", 32'(switch_ram), 32'd0);
        px(1'b0, 1'b0, 24'h0);
        chk("t3.fin.sw", 32'(switch_ram), 32'd1);

        // ---------------- reset in the middle of a frame
        pulse_start();
        px(1'b0, 1'b0, 24'h0);
        frame_run("t4pre", 20, 1'b0);
        rst_n = 1'b0;
        px(1'b1, 1'b0, 24'h555555);
        chk_all_zero("t4rst");
        rst_n = 1'b1;
        px(1'b1, 1'b1, 24'h666666);
        chk("t4.rel.en",   32'(ram.wr_en), 32'd0);
        chk("t4.rel.busy", 32'(busy),      32'd0);
        pulse_start();
        px(1'b0, 1'b0, 24'h0);
        frame_run("t4", TB_FP, 1'b0);
        chk("t4.last.done", 32'(pic_done), 32'd0);
        px(1'b0, 1'b0, 24'h0);
        chk("t4.fin.done", 32'(pic_done),   32'd1);
        chk("t4.fin.sw",   32'(switch_ram), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
